// File: rtl/mem_wb_if.sv
// MEM->WB stage bus: incoming MEM-stage instruction, pipeline control,
// data SRAM read data and the outgoing register-file write port.
interface mem_wb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_DEPTH  = 32,
  parameter int unsigned INSTRET_W  = 64
);
  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic                  stall_i;
  logic                  flush_i;
  logic                  mem_valid_i;
  logic                  mem_regwrite_i;
  logic [AW-1:0]         mem_rd_addr_i;
  logic [1:0]            mem_wb_sel_i;
  logic [2:0]            mem_funct3_i;
  logic [DATA_WIDTH-1:0] mem_alu_result_i;
  logic [DATA_WIDTH-1:0] mem_pc_plus4_i;
  logic [DATA_WIDTH-1:0] dmem_rdata_i;

  logic [AW-1:0]         rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  RegWrite_o;
  logic                  load_err_o;
  logic [INSTRET_W-1:0]  instret_o;

  // Upstream pipeline / SRAM side
  modport master (
    output stall_i, flush_i, mem_valid_i, mem_regwrite_i, mem_rd_addr_i,
           mem_wb_sel_i, mem_funct3_i, mem_alu_result_i, mem_pc_plus4_i,
           dmem_rdata_i,
    input  rd_addr_o, rd_data_o, RegWrite_o, load_err_o, instret_o
  );

  // Writeback stage side
  modport slave (
    input  stall_i, flush_i, mem_valid_i, mem_regwrite_i, mem_rd_addr_i,
           mem_wb_sel_i, mem_funct3_i, mem_alu_result_i, mem_pc_plus4_i,
           dmem_rdata_i,
    output rd_addr_o, rd_data_o, RegWrite_o, load_err_o, instret_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: registers the MEM result, holds SRAM load data across
// stalls, formats loads, drives the register-file write port and instret.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_DEPTH  = 32,
  parameter int unsigned INSTRET_W  = 64
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  mem_wb_if.slave bus
);
  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  typedef struct packed {
    logic                  regwrite;
    logic [AW-1:0]         rd_addr;
    logic [1:0]            sel;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } wb_payload_t;

  logic                  wb_valid_q;
  wb_payload_t           wb_q;
  wb_payload_t           mem_payload;
  logic                  hold_valid_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q;
  logic [INSTRET_W-1:0]  instret_q;

  logic                  wb_is_load;
  logic [1:0]            wb_off;
  logic [DATA_WIDTH-1:0] load_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic                  bad_access;
  logic                  load_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  retire;

  assign mem_payload = '{regwrite:   bus.mem_regwrite_i,
                         rd_addr:    bus.mem_rd_addr_i,
                         sel:        bus.mem_wb_sel_i,
                         funct3:     bus.mem_funct3_i,
                         alu_result: bus.mem_alu_result_i,
                         pc_plus4:   bus.mem_pc_plus4_i};

  assign wb_is_load = wb_valid_q && (wb_q.sel == SEL_LOAD);
  assign wb_off     = wb_q.alu_result[1:0];

  // SRAM data is only valid in the first WB cycle; later stalled cycles use the hold copy
  assign load_word = hold_valid_q ? rdata_hold_q : bus.dmem_rdata_i;
  assign ld_byte   = load_word[{wb_off, 3'b000} +: 8];
  assign ld_half   = load_word[{wb_off[1], 4'b0000} +: 16];

  always_comb begin
    load_fmt   = '0;
    bad_access = 1'b0;
    case (wb_q.funct3)
      3'b000: load_fmt = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100: load_fmt = DATA_WIDTH'(ld_byte);
      3'b001: begin
        load_fmt   = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        bad_access = wb_off[0];
      end
      3'b101: begin
        load_fmt   = DATA_WIDTH'(ld_half);
        bad_access = wb_off[0];
      end
      3'b010: begin
        load_fmt   = load_word;
        bad_access = (wb_off != 2'b00);
      end
      default: bad_access = 1'b1;
    endcase
  end

  assign load_err = wb_is_load && bad_access;

  // Writeback source select; reserved encoding falls back to the ALU result
  always_comb begin
    rd_data = wb_q.alu_result;
    case (wb_q.sel)
      SEL_LOAD: rd_data = load_err ? '0 : load_fmt;
      SEL_PC4:  rd_data = wb_q.pc_plus4;
      SEL_ALU:  rd_data = wb_q.alu_result;
      default:  rd_data = wb_q.alu_result;
    endcase
  end

  assign retire = wb_valid_q && !bus.stall_i && !load_err;

  // Stall beats flush beats normal advance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q   <= 1'b0;
      wb_q         <= '0;
      hold_valid_q <= 1'b0;
      rdata_hold_q <= '0;
      instret_q    <= '0;
    end else begin
      if (bus.stall_i) begin
        if (wb_is_load && !hold_valid_q) begin
          rdata_hold_q <= bus.dmem_rdata_i;
          hold_valid_q <= 1'b1;
        end
      end else if (bus.flush_i) begin
        wb_valid_q   <= 1'b0;
        hold_valid_q <= 1'b0;
      end else begin
        wb_valid_q   <= bus.mem_valid_i;
        wb_q         <= mem_payload;
        hold_valid_q <= 1'b0;
      end
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  assign bus.rd_addr_o  = wb_q.rd_addr;
  assign bus.rd_data_o  = rd_data;
  assign bus.RegWrite_o = wb_valid_q && wb_q.regwrite && (wb_q.rd_addr != '0) && !load_err;
  assign bus.load_err_o = load_err;
  assign bus.instret_o  = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic, all checked
// against an instruction-level model of what the WB stage should write.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_if #(.DATA_WIDTH(32), .REG_DEPTH(32), .INSTRET_W(64)) bus ();

  mem_wb_stage #(.DATA_WIDTH(32), .REG_DEPTH(32), .INSTRET_W(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
  } instr_t;

  int n_checks = 0;
  int n_err    = 0;

  // Model: the instruction currently in WB, the SRAM word seen in its first WB cycle, retire count
  instr_t      m_wb;
  logic [31:0] m_first;
  bit          m_firstcyc;
  logic [63:0] m_instret;

  function automatic instr_t mk(logic v, logic rw, logic [4:0] rd, logic [1:0] sel,
                                logic [2:0] f3, logic [31:0] alu, logic [31:0] pc4);
    instr_t t;
    t.valid = v; t.regwrite = rw; t.rd = rd; t.sel = sel;
    t.f3 = f3; t.alu = alu; t.pc4 = pc4;
    return t;
  endfunction

  function automatic logic [31:0] fmt(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit is_err(instr_t t);
    if (!(t.valid && t.sel == 2'b01)) return 1'b0;
    case (t.f3)
      3'b011, 3'b110, 3'b111: return 1'b1;
      3'b001, 3'b101:         return t.alu[0];
      3'b010:                 return t.alu[1:0] != 2'b00;
      default:                return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, then advance model and clock
  task automatic step(input instr_t in, input bit st, input bit fl, input logic [31:0] dm,
                      input bit use_exp, input logic [31:0] exp_d);
    bit          e_err;
    bit          e_we;
    logic [31:0] e_data;
    bus.mem_valid_i      = in.valid;
    bus.mem_regwrite_i   = in.regwrite;
    bus.mem_rd_addr_i    = in.rd;
    bus.mem_wb_sel_i     = in.sel;
    bus.mem_funct3_i     = in.f3;
    bus.mem_alu_result_i = in.alu;
    bus.mem_pc_plus4_i   = in.pc4;
    bus.stall_i          = st;
    bus.flush_i          = fl;
    bus.dmem_rdata_i     = dm;
    #1;
    if (m_firstcyc) m_first = dm;
    e_err = is_err(m_wb);
    e_we  = m_wb.valid && m_wb.regwrite && (m_wb.rd != 5'd0) && !e_err;
    if (m_wb.sel == 2'b01)      e_data = e_err ? 32'h0 : fmt(m_wb.f3, m_wb.alu[1:0], m_first);
    else if (m_wb.sel == 2'b10) e_data = m_wb.pc4;
    else                        e_data = m_wb.alu;
    check("regwrite", 64'(bus.RegWrite_o), 64'(e_we));
    check("load_err", 64'(bus.load_err_o), 64'(e_err));
    check("instret",  bus.instret_o, m_instret);
    if (m_wb.valid) begin
      check("rd_addr", 64'(bus.rd_addr_o), 64'(m_wb.rd));
      check("rd_data", 64'(bus.rd_data_o), 64'(e_data));
    end
    if (use_exp) check("directed_data", 64'(bus.rd_data_o), 64'(exp_d));
    if (m_wb.valid && !st && !e_err) m_instret = m_instret + 64'd1;
    if (st) begin
      m_firstcyc = 1'b0;
    end else if (fl) begin
      m_wb.valid = 1'b0;
      m_firstcyc = 1'b0;
    end else begin
      m_wb       = in;
      m_firstcyc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wb       = '0;
    m_first    = '0;
    m_firstcyc = 1'b0;
    m_instret  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"},  64'(bus.rd_addr_o),  64'd0);
    check({tag, "_rd_data"},  64'(bus.rd_data_o),  64'd0);
    check({tag, "_regwrite"}, 64'(bus.RegWrite_o), 64'd0);
    check({tag, "_load_err"}, 64'(bus.load_err_o), 64'd0);
    check({tag, "_instret"},  bus.instret_o,       64'd0);
  endtask

  initial begin
    instr_t      nop;
    instr_t      ld;
    logic [2:0]  lf3  [5];
    logic [1:0]  loff [5];
    logic [31:0] lexp [5];
    nop = '0;
    model_reset();
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.mem_valid_i = 1'b0;
    bus.mem_regwrite_i = 1'b0; bus.mem_rd_addr_i = '0; bus.mem_wb_sel_i = '0;
    bus.mem_funct3_i = '0; bus.mem_alu_result_i = '0; bus.mem_pc_plus4_i = '0;
    bus.dmem_rdata_i = 32'hA5A5_A5A5;

    // Reset state
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU write to rd=5
    step(mk(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0), 0, 0, $urandom, 0, 0);
    step(nop, 0, 0, $urandom, 1, 32'h1234_5678);
    step(nop, 0, 0, $urandom, 0, 0);

    // Load formatting on 0x80FF_7F01
    lf3[0] = 3'b000; loff[0] = 2'd3; lexp[0] = 32'hFFFF_FF80;
    lf3[1] = 3'b100; loff[1] = 2'd3; lexp[1] = 32'h0000_0080;
    lf3[2] = 3'b001; loff[2] = 2'd2; lexp[2] = 32'hFFFF_80FF;
    lf3[3] = 3'b101; loff[3] = 2'd0; lexp[3] = 32'h0000_7F01;
    lf3[4] = 3'b010; loff[4] = 2'd0; lexp[4] = 32'h80FF_7F01;
    step(mk(1, 1, 5'd3, 2'b01, lf3[0], {30'h400, loff[0]}, 32'h0), 0, 0, $urandom, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) ld = mk(1, 1, 5'd3, 2'b01, lf3[i+1], {30'h400, loff[i+1]}, 32'h0);
      else       ld = nop;
      step(ld, 0, 0, 32'h80FF_7F01, 1, lexp[i]);
    end

    // Stall with SRAM data changing underneath
    step(mk(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_2000, 32'h0), 0, 0, $urandom, 0, 0);
    step(nop, 1, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    step(nop, 1, 0, 32'h0,         1, 32'hDEAD_BEEF);
    step(nop, 1, 0, 32'h0,         1, 32'hDEAD_BEEF);
    step(nop, 0, 0, 32'h0,         1, 32'hDEAD_BEEF);
    step(nop, 0, 0, 32'h0,         0, 0);

    // Misaligned and illegal loads
    step(mk(1, 1, 5'd8, 2'b01, 3'b010, 32'h0000_2002, 32'h0), 0, 0, $urandom, 0, 0);
    step(mk(1, 1, 5'd8, 2'b01, 3'b001, 32'h0000_2001, 32'h0), 0, 0, $urandom, 1, 32'h0);
    step(mk(1, 1, 5'd8, 2'b01, 3'b011, 32'h0000_2000, 32'h0), 0, 0, $urandom, 1, 32'h0);
    step(nop, 0, 0, $urandom, 1, 32'h0);

    // x0 write and JAL link value
    step(mk(1, 1, 5'd0, 2'b00, 3'b000, 32'h0000_ABCD, 32'h0), 0, 0, $urandom, 0, 0);
    step(mk(1, 1, 5'd1, 2'b10, 3'b000, $urandom, 32'h0000_0104), 0, 0, $urandom, 0, 0);
    step(nop, 0, 0, $urandom, 1, 32'h0000_0104);

    // Flush replaces the incoming instruction but the one in WB retires
    step(mk(1, 1, 5'd9, 2'b00, 3'b000, 32'h0000_0099, 32'h0), 0, 0, $urandom, 0, 0);
    step(mk(1, 1, 5'd10, 2'b00, 3'b000, 32'h0000_0AAA, 32'h0), 0, 1, $urandom, 1, 32'h0000_0099);
    step(nop, 0, 0, $urandom, 0, 0);

    // Asynchronous reset while a load is held by a stall
    step(mk(1, 1, 5'd11, 2'b01, 3'b010, 32'h0000_3000, 32'h0), 0, 0, 32'h0, 0, 0);
    step(nop, 1, 0, 32'h1111_2222, 1, 32'h1111_2222);
    bus.stall_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 1, 5'd12, 2'b01, 3'b010, 32'h0000_3000, 32'h0), 0, 0, $urandom, 0, 0);
    step(nop, 1, 0, 32'h3333_4444, 1, 32'h3333_4444);
    step(nop, 0, 0, 32'h0,         1, 32'h3333_4444);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ld = mk(($urandom % 8) != 0, ($urandom % 4) != 0,
              (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
              2'($urandom), 3'($urandom), $urandom, $urandom);
      step(ld, ($urandom % 10) < 3, ($urandom % 10) == 0, $urandom, 0, 0);
    end
    step(nop, 0, 0, $urandom, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback pipeline stage between the MEM stage and the register file.
- Registers the MEM-stage result and captures load data from the one-cycle-delay data SRAM, holding it stable across stalls.
- Aligns and extends load data, then selects the writeback source.
- Drives the register-file write port (rd_addr/rd_data/RegWrite) and keeps a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath width; byte/halfword logic is defined for 32.
- REG_DEPTH, 32, register count; rd address width is clog2(REG_DEPTH).
- INSTRET_W, 64, retired-instruction counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- stall_i  in  1  hold WB contents; highest priority.
- flush_i  in  1  replace the incoming MEM instruction with a bubble.
- mem_valid_i  in  1  MEM stage holds a real instruction.
- mem_regwrite_i  in  1  instruction writes rd.
- mem_rd_addr_i  in  clog2(REG_DEPTH)  destination register.
- mem_wb_sel_i  in  2  00 ALU result, 01 load, 10 PC+4, 11 reserved (treated as 00).
- mem_funct3_i  in  3  load type.
- mem_alu_result_i  in  DATA_WIDTH  ALU result / load address.
- mem_pc_plus4_i  in  DATA_WIDTH  link value.
- dmem_rdata_i  in  DATA_WIDTH  SRAM read data; valid only in the first cycle a load occupies WB.
- rd_addr_o  out  clog2(REG_DEPTH)  register-file write address.
- rd_data_o  out  DATA_WIDTH  register-file write data.
- RegWrite_o  out  1  register-file write enable.
- load_err_o  out  1  WB load is misaligned or has an illegal funct3.
- instret_o  out  INSTRET_W  count of retired instructions.

Behaviour:
- Reset (rst_ni=0, asynchronous): all WB registers, hold_valid, rdata_hold and instret clear to 0.
  - Outputs after reset: rd_addr_o=0, rd_data_o=0, RegWrite_o=0, load_err_o=0, instret_o=0.
- Each rising edge, priority order:
  - stall_i=1: all WB registers hold. If a load is valid in WB and hold_valid=0, set rdata_hold<=dmem_rdata_i and hold_valid<=1.
  - else flush_i=1: wb_valid<=0, hold_valid<=0; the other fields are don't-care.
  - else: capture all mem_* inputs (wb_valid<=mem_valid_i) and set hold_valid<=0.
- Reset mid-stall discards the held data.
- Latency: an instruction presented on mem_* at edge N drives the write port during cycle N..N+1.
- Outputs are combinational from the WB registers.
- Load data source: rdata_hold when hold_valid=1, else dmem_rdata_i.
- Byte offset off = wb_alu_result[1:0]. Load formatting:
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 101 LHU: zero-extend half[off[1]].
  - 010 LW: full word.
  - Byte lanes are little-endian.
- load_err_o = wb_valid & (wb_sel=01) & (funct3 in {011,110,111}, or LH/LHU with off[0]=1, or LW with off!=0).
  - On error: rd_data_o=0 and no write.
- rd_data_o by wb_sel: 00/11 ALU result, 01 formatted load, 10 PC+4. It is driven even when no write occurs.
- rd_addr_o = wb_rd_addr.
- RegWrite_o = wb_valid & wb_regwrite & (wb_rd_addr!=0) & !load_err_o.
  - Asserts every cycle the instruction sits in WB, including stalled cycles. The write is idempotent, and the register file's same-cycle bypass sees it.
- Retire = wb_valid & !stall_i & !load_err_o. instret_o increments by 1 on the edge where retire=1.
  - Wraps from all-ones to 0.
  - An instruction with rd=x0 still retires.
- flush_i never kills the instruction already in WB; that instruction retires on the same edge.

Test Plan:
- ALU write: rd=5, sel=00, alu=0x1234_5678, no stall -> next cycle RegWrite_o=1, rd_addr_o=5, rd_data_o=0x1234_5678; instret 0->1 on the following edge.
- Loads on dmem=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW off=0 -> 0x80FF_7F01.
- Stall with SRAM change: LW to rd=7, dmem=0xDEAD_BEEF in the first WB cycle, stall_i=1 for 3 cycles while dmem changes to 0x0 -> rd_data_o stays 0xDEAD_BEEF every cycle; instret increments exactly once, at release.
- Misaligned/illegal: LW off=2, then LH off=1, then funct3=011 -> load_err_o=1, RegWrite_o=0, rd_data_o=0, instret unchanged.
- x0 and JAL: regwrite to rd=0 -> RegWrite_o=0, instret increments. sel=10 with pc_plus4=0x0000_0104 to rd=1 -> rd_data_o=0x0000_0104.
- Flush and reset:
  - flush_i with a valid MEM instruction -> next cycle RegWrite_o=0; the instruction already in WB still retires.
  - Assert rst_ni=0 mid-stall asynchronously -> all outputs 0 immediately, instret_o=0, held data discarded.
